// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - demand-actuated round-robin phase scheduler for a 4-way junction
//
// Purpose: grants right-of-way to one of four approaches based on vehicle
// presence, enforcing min/max green, fixed yellow and all-red clearance, with
// emergency preemption towards a selected approach.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   req[3:0]    vehicle presence per approach (bit i = approach i+1), level
//   emg_valid   emergency preempt request, level
//   emg_dir     preempt target approach (0 = r1 .. 3 = r4)
//   r1..r4      lamp per approach: 00 red, 01 yellow, 10 green
//   active_dir  approach currently (or last) holding right-of-way
//   green_on    high while any lamp is green
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       emg_valid,
  input  logic [1:0] emg_dir,
  output logic [1:0] r1,
  output logic [1:0] r2,
  output logic [1:0] r3,
  output logic [1:0] r4,
  output logic [1:0] active_dir,
  output logic       green_on
);

  localparam logic [CW-1:0] MIN_T = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_T = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] YEL_T = CW'(YELLOW - 1);
  localparam logic [CW-1:0] AR_T  = CW'(ALL_RED - 1);
  localparam logic [CW-1:0] AR_N  = CW'(ALL_RED);

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_GRN = 2'b10;

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW_S, ALLRED} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   timer_q, timer_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      active_q, active_d;
  logic [3:0][1:0] lamp_q, lamp_d;
  logic            green_q, green_d;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       demand;
  logic       other;

  // Round-robin search starting just after the last served approach, so the
  // approach just served only wins again when nobody else is asking.
  always_comb begin
    winner = last_q + 2'd1;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = last_q + 2'(k + 1);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    if (emg_valid) winner = emg_dir;
  end

  assign demand = emg_valid | (|req);
  assign other  = |(req & ~(4'b0001 << active_q));

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    active_d = active_q;
    timer_d  = timer_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (demand) begin
          state_d  = GREEN;
          last_d   = winner;
          active_d = winner;
        end
      end
      GREEN: begin
        if (timer_q == MAX_T) timer_d = timer_q;
        if (emg_valid && (emg_dir != active_q))       state_d = YELLOW_S;
        else if (emg_valid)                           state_d = GREEN;
        else if ((timer_q >= MIN_T) && !req[active_q]) state_d = YELLOW_S;
        else if ((timer_q >= MAX_T) && other)         state_d = YELLOW_S;
      end
      YELLOW_S: begin
        if (timer_q == YEL_T) state_d = ALLRED;
      end
      ALLRED: begin
        if (timer_q == AR_T) begin
          if (demand) begin
            state_d  = GREEN;
            last_d   = winner;
            active_d = winner;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
    if (state_q == IDLE && state_d == IDLE) timer_d = '0;

    // Lamps are computed from the next state so they register alongside it.
    lamp_d = '0;
    if (state_d == GREEN)    lamp_d[active_d] = LAMP_GRN;
    if (state_d == YELLOW_S) lamp_d[active_d] = LAMP_YEL;
    green_d = (state_d == GREEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      last_q   <= 2'd3;
      active_q <= 2'd0;
      lamp_q   <= '0;
      green_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      last_q   <= last_d;
      active_q <= active_d;
      lamp_q   <= lamp_d;
      green_q  <= green_d;
    end
  end

  assign r1         = lamp_q[0];
  assign r2         = lamp_q[1];
  assign r3         = lamp_q[2];
  assign r4         = lamp_q[3];
  assign active_dir = active_q;
  assign green_on   = green_q;

  // Safety invariants on the lamp outputs.
  logic [3:0][1:0] prev_lamp_q;
  logic [CW-1:0]   red_run_q;
  logic            all_red;
  logic            any_green;
  logic            prev_green;

  assign all_red    = (lamp_q == '0);
  assign any_green  = (lamp_q[0] == LAMP_GRN) | (lamp_q[1] == LAMP_GRN) |
                      (lamp_q[2] == LAMP_GRN) | (lamp_q[3] == LAMP_GRN);
  assign prev_green = (prev_lamp_q[0] == LAMP_GRN) | (prev_lamp_q[1] == LAMP_GRN) |
                      (prev_lamp_q[2] == LAMP_GRN) | (prev_lamp_q[3] == LAMP_GRN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_lamp_q <= '0;
      red_run_q   <= AR_N;
    end else begin
      prev_lamp_q <= lamp_q;
      if (!all_red)          red_run_q <= '0;
      else if (red_run_q != AR_N) red_run_q <= red_run_q + 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert ((lamp_q[0] != LAMP_RED) + (lamp_q[1] != LAMP_RED) +
              (lamp_q[2] != LAMP_RED) + (lamp_q[3] != LAMP_RED) <= 1);
      for (int i = 0; i < 4; i++) begin
        assert (lamp_q[i] != 2'b11);
        if (prev_lamp_q[i] == LAMP_GRN && lamp_q[i] != LAMP_GRN)
          assert (lamp_q[i] == LAMP_YEL);
      end
      if (any_green && !prev_green) assert (red_run_q >= AR_N);
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - scoreboard bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       emg_valid;
  logic [1:0] emg_dir;
  logic [1:0] r1, r2, r3, r4;
  logic [1:0] active_dir;
  logic       green_on;

  traffic_phase_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .emg_valid  (emg_valid),
    .emg_dir    (emg_dir),
    .r1         (r1),
    .r2         (r2),
    .r3         (r3),
    .r4         (r4),
    .active_dir (active_dir),
    .green_on   (green_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] lamps;
    logic [1:0] act;
    logic       grn;
    int         step;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   step_n = 0;

  function automatic logic [7:0] lamp(input int a, input logic [1:0] code);
    logic [7:0] v;
    v = {6'b0, code};
    return v << (2 * a);
  endfunction

  // Drive this cycle's inputs and queue the outputs expected during it.
  task automatic tick(input logic r, input logic [3:0] rq, input logic ev,
                      input logic [1:0] ed, input logic [7:0] el,
                      input logic [1:0] ea, input logic eg);
    exp_t e;
    rst       = r;
    req       = rq;
    emg_valid = ev;
    emg_dir   = ed;
    e.lamps   = el;
    e.act     = ea;
    e.grn     = eg;
    e.step    = step_n;
    step_n++;
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [3:0] rq, input logic ev,
                     input logic [1:0] ed, input int a, input logic [1:0] code,
                     input logic [1:0] ea);
    for (int i = 0; i < n; i++)
      tick(1'b0, rq, ev, ed, lamp(a, code), ea, code == GRN);
  endtask

  task automatic reset_pulse();
    tick(1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      n_vec++;
      if ({r4, r3, r2, r1} !== e_mon.lamps) begin
        n_bad++;
        $display("FAIL lamps step %0d: got %b, expected %b", e_mon.step, {r4, r3, r2, r1}, e_mon.lamps);
      end
      n_vec++;
      if (active_dir !== e_mon.act) begin
        n_bad++;
        $display("FAIL active_dir step %0d: got %0d, expected %0d", e_mon.step, active_dir, e_mon.act);
      end
      n_vec++;
      if (green_on !== e_mon.grn) begin
        n_bad++;
        $display("FAIL green_on step %0d: got %b, expected %b", e_mon.step, green_on, e_mon.grn);
      end
    end
  end

  initial begin
    rst = 1'b1; req = 4'b0000; emg_valid = 1'b0; emg_dir = 2'd0;
    @(posedge clk);
    #1;

    // Reset, then a long idle stretch with no demand.
    reset_pulse();
    reset_pulse();
    run(30, 4'b0000, 1'b0, 2'd0, 0, RED, 2'd0);

    // Sole demand on approach 1 rests in green.
    run(1, 4'b0001, 1'b0, 2'd0, 0, RED, 2'd0);
    run(35, 4'b0001, 1'b0, 2'd0, 0, GRN, 2'd0);

    // Max-out: approach 2 starts asking at green cycle 2.
    reset_pulse();
    run(1, 4'b0001, 1'b0, 2'd0, 0, RED, 2'd0);
    run(1, 4'b0001, 1'b0, 2'd0, 0, GRN, 2'd0);
    run(11, 4'b0011, 1'b0, 2'd0, 0, GRN, 2'd0);
    run(3, 4'b0011, 1'b0, 2'd0, 0, YEL, 2'd0);
    run(1, 4'b0011, 1'b0, 2'd0, 0, RED, 2'd0);
    run(2, 4'b0011, 1'b0, 2'd0, 1, GRN, 2'd1);

    // Gap-out: one-cycle pulse on approach 1, approach 3 held.
    reset_pulse();
    run(1, 4'b0101, 1'b0, 2'd0, 0, RED, 2'd0);
    run(4, 4'b0100, 1'b0, 2'd0, 0, GRN, 2'd0);
    run(3, 4'b0100, 1'b0, 2'd0, 0, YEL, 2'd0);
    run(1, 4'b0100, 1'b0, 2'd0, 0, RED, 2'd0);
    run(3, 4'b0100, 1'b0, 2'd0, 2, GRN, 2'd2);

    // Full demand: round robin r1, r2, r3, r4, r1.
    reset_pulse();
    run(1, 4'b1111, 1'b0, 2'd0, 0, RED, 2'd0);
    for (int k = 0; k < 5; k++) begin
      run(12, 4'b1111, 1'b0, 2'd0, k % 4, GRN, 2'(k % 4));
      if (k < 4) begin
        run(3, 4'b1111, 1'b0, 2'd0, k % 4, YEL, 2'(k % 4));
        run(1, 4'b1111, 1'b0, 2'd0, k % 4, RED, 2'(k % 4));
      end
    end

    // Emergency preempt towards approach 3, then reset mid-yellow.
    reset_pulse();
    run(1, 4'b0001, 1'b0, 2'd0, 0, RED, 2'd0);
    run(1, 4'b0001, 1'b0, 2'd0, 0, GRN, 2'd0);
    run(1, 4'b0001, 1'b1, 2'd2, 0, GRN, 2'd0);
    run(3, 4'b0001, 1'b1, 2'd2, 0, YEL, 2'd0);
    run(1, 4'b0001, 1'b1, 2'd2, 0, RED, 2'd0);
    run(20, 4'b0001, 1'b1, 2'd2, 2, GRN, 2'd2);
    run(1, 4'b0001, 1'b1, 2'd0, 2, GRN, 2'd2);
    run(1, 4'b0001, 1'b1, 2'd0, 2, YEL, 2'd2);
    tick(1'b1, 4'b0001, 1'b1, 2'd0, 8'h00, 2'd0, 1'b0);
    run(1, 4'b0001, 1'b1, 2'd0, 0, RED, 2'd0);
    run(4, 4'b0001, 1'b1, 2'd0, 0, GRN, 2'd0);

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
